// File: rtl/sigmon_pkg.sv
// Shared types and elaboration helpers for the signature monitor.
// Holds the run-state encoding and the accumulator width sanity check.
package sigmon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sigmon_state_t;

  // The rotate step moves one bit above the sum and one below it, so two spare bits are needed.
  function automatic bit acc_width_ok(input int acc_w, input int data_w);
    return acc_w >= data_w + 2;
  endfunction

endpackage

// File: rtl/sigmon_scrambler.sv
// Combinational XOR fold of the captured seed with every probe word.
// Word k of the flattened probe bus lives at [k*DATA_W +: DATA_W].
module sigmon_scrambler #(
  parameter int DATA_W   = 8,
  parameter int N_PROBES = 12
) (
  input  logic [DATA_W-1:0]          seed,
  input  logic [N_PROBES*DATA_W-1:0] probes,
  output logic [DATA_W-1:0]          scr
);

  always_comb begin
    scr = seed;
    for (int k = 0; k < N_PROBES; k++) begin
      scr = scr ^ probes[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/signature_monitor.sv
// Self-test signature analyser: sweeps a stimulus counter, folds scrambled probe
// words into a rotate-and-add accumulator, and compares the result at the end of a run.
module signature_monitor
  import sigmon_pkg::*;
#(
  parameter int STIM_W   = 8,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int N_PROBES = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       chain,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          seed,
  input  logic [ACC_W-1:0]           expected,
  input  logic [N_PROBES*DATA_W-1:0] probes,
  output logic [STIM_W-1:0]          stimulus,
  output logic [ACC_W-1:0]           signature,
  output logic                       busy,
  output logic                       sig_valid,
  output logic                       match
);

  if (!acc_width_ok(ACC_W, DATA_W)) begin : g_bad_acc_w
    $error("signature_monitor: ACC_W must be at least DATA_W+2");
  end

  sigmon_state_t     state;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] scr;
  logic              stim_full;

  // Low word gets the modular sum; the whole word then rotates left by one.
  function automatic logic [ACC_W-1:0] rotate_add(input logic [ACC_W-1:0]  acc_in,
                                                 input logic [DATA_W-1:0] scr_in);
    logic [DATA_W-1:0] sum;
    sum = acc_in[DATA_W-1:0] + scr_in;
    return {acc_in[ACC_W-2:DATA_W], sum, acc_in[ACC_W-1]};
  endfunction

  sigmon_scrambler #(
    .DATA_W  (DATA_W),
    .N_PROBES(N_PROBES)
  ) u_scrambler (
    .seed  (seed_q),
    .probes(probes),
    .scr   (scr)
  );

  assign stim_full = &stimulus;
  assign signature = acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stimulus  <= '0;
      acc       <= '0;
      seed_q    <= '0;
      busy      <= 1'b0;
      sig_valid <= 1'b0;
      match     <= 1'b0;
    end else begin
      sig_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            stimulus <= '0;
            seed_q   <= seed;
            acc      <= chain ? acc : '0;
            match    <= 1'b0;
            busy     <= 1'b1;
          end else if (clear) begin
            state    <= IDLE;
            stimulus <= '0;
            acc      <= '0;
            match    <= 1'b0;
          end
        end
        RUN: begin
          // start and clear are deliberately ignored here; only reset aborts a run.
          if (stim_full) begin
            state     <= DONE;
            busy      <= 1'b0;
            sig_valid <= 1'b1;
            match     <= (acc == expected);
          end else begin
            acc      <= rotate_add(acc, scr);
            stimulus <= stimulus + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
